// File: rtl/reflet_periph_pkg.sv
// reflet_periph_pkg: shared status-byte layout, register offsets and handshake state encodings
package reflet_periph_pkg;
    localparam int STAT_PENDING_BIT  = 0;
    localparam int STAT_OVERFLOW_BIT = 1;
    localparam int STAT_CNT_LSB      = 4;
    localparam int STAT_CNT_W        = 4;
    localparam int CMD_OFFSET        = 0;
    localparam int STAT_OFFSET       = 1;
    typedef enum logic {
        STATE_IDLE    = 1'b0,
        STATE_PENDING = 1'b1
    } state_t;
endpackage

// File: rtl/reflet_sat_counter.sv
// reflet_sat_counter: up-counter with synchronous clear that saturates at all-ones
module reflet_sat_counter #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] value
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            value <= '0;
        else if (inc && value != '1)
            value <= value + width'(1);
    end
endmodule

// File: rtl/reflet_cmd_register.sv
// reflet_cmd_register: bus-writable command byte with valid/ack handshake and dropped-write tracking
module reflet_cmd_register
    import reflet_periph_pkg::*;
#(
    parameter int                   addr_size   = 16,
    parameter logic [addr_size-1:0] reg_addr    = '0,
    parameter logic [7:0]           reset_value = 8'h00,
    parameter logic [7:0]           clear_mask  = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [addr_size-1:0] addr,
    input  logic                 write_en,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic [7:0]           cmd,
    output logic                 cmd_valid,
    input  logic                 cmd_ack
);
    // Status address wraps modulo 2^addr_size.
    localparam logic [addr_size-1:0] CMD_ADDR  = addr_size'(reg_addr + CMD_OFFSET);
    localparam logic [addr_size-1:0] STAT_ADDR = addr_size'(reg_addr + STAT_OFFSET);

    state_t                  state, state_nxt;
    logic [7:0]              cmd_reg, cmd_nxt, status;
    logic                    overflow, drop, stat_clr, pending;
    logic [STAT_CNT_W-1:0]   drop_cnt;
    logic                    wr_cmd, wr_stat, rd_cmd, rd_stat;

    assign wr_cmd    = enable &  write_en & (addr == CMD_ADDR);
    assign wr_stat   = enable &  write_en & (addr == STAT_ADDR);
    assign rd_cmd    = enable & ~write_en & (addr == CMD_ADDR);
    assign rd_stat   = enable & ~write_en & (addr == STAT_ADDR);
    assign stat_clr  = wr_stat & data_in[1];
    assign pending   = (state == STATE_PENDING);
    assign cmd       = cmd_reg;
    assign cmd_valid = pending;

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_reg;
        drop      = 1'b0;
        if (!pending) begin
            if (wr_cmd) begin
                cmd_nxt   = data_in;
                state_nxt = STATE_PENDING;
            end
        end else if (wr_cmd) begin
            // A write coinciding with the ack replaces the consumed command and stays pending.
            cmd_nxt = cmd_ack ? data_in : cmd_reg;
            drop    = ~cmd_ack;
        end else if (cmd_ack) begin
            cmd_nxt   = cmd_reg & ~clear_mask;
            state_nxt = STATE_IDLE;
        end
    end

    always_comb begin
        status                                 = '0;
        status[STAT_PENDING_BIT]               = pending;
        status[STAT_OVERFLOW_BIT]              = overflow;
        status[STAT_CNT_LSB +: STAT_CNT_W]     = drop_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= STATE_IDLE;
            cmd_reg  <= reset_value;
            overflow <= 1'b0;
            data_out <= 8'h00;
        end else begin
            state    <= state_nxt;
            cmd_reg  <= cmd_nxt;
            overflow <= stat_clr ? 1'b0 : (overflow | drop);
            data_out <= rd_cmd ? cmd_reg : rd_stat ? status : 8'h00;
        end
    end

    reflet_sat_counter #(.width(STAT_CNT_W)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop),
        .clr   (stat_clr),
        .value (drop_cnt)
    );
endmodule

// File: tb/tb_reflet_cmd_register.sv
// tb_reflet_cmd_register: randomized scoreboard bench against a behavioural model of the command register
module tb_reflet_cmd_register;
    localparam logic [15:0] REG  = 16'hFFFF;
    localparam logic [15:0] STAT = 16'h0000;
    localparam logic [7:0]  RV   = 8'h24;
    localparam logic [7:0]  CM   = 8'h81;

    typedef struct packed {
        logic [7:0] dout;
        logic [7:0] cmd;
        logic       vld;
    } exp_t;

    logic        clk, reset, enable, write_en, cmd_ack, cmd_valid;
    logic [15:0] addr;
    logic [7:0]  data_in, data_out, cmd;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] m_cmd;
    bit         m_pend, m_ovf;
    int         m_drops;
    logic [7:0] m_dout;

    reflet_cmd_register #(
        .addr_size(16), .reg_addr(REG), .reset_value(RV), .clear_mask(CM)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
        .data_in(data_in), .data_out(data_out), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] m_status();
        return 8'(m_drops * 16 + (m_ovf ? 2 : 0) + (m_pend ? 1 : 0));
    endfunction

    task automatic step(input bit rst, input bit en, input bit we, input logic [15:0] a,
                        input logic [7:0] d, input bit ack);
        bit is_cmd, is_stat;
        logic [7:0] dn;
        @(negedge clk);
        reset = rst; enable = en; write_en = we; addr = a; data_in = d; cmd_ack = ack;
        if (rst) begin
            m_cmd = RV; m_pend = 0; m_ovf = 0; m_drops = 0; m_dout = 8'h00;
        end else begin
            is_cmd  = en && a == REG;
            is_stat = en && a == STAT;
            dn = (is_cmd && !we) ? m_cmd : (is_stat && !we) ? m_status() : 8'h00;
            if (is_cmd && we) begin
                if (!m_pend) begin
                    m_cmd = d; m_pend = 1;
                end else if (ack) m_cmd = d;
                else begin
                    m_ovf = 1;
                    m_drops = (m_drops < 15) ? m_drops + 1 : 15;
                end
            end else if (m_pend && ack) begin
                m_cmd = m_cmd & ~CM;
                m_pend = 0;
            end
            if (is_stat && we && d[1]) begin
                m_ovf = 0; m_drops = 0;
            end
            m_dout = dn;
        end
        q.push_back('{dout: m_dout, cmd: m_cmd, vld: m_pend});
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit ack);
        step(0, 1, 1, a, d, ack);
    endtask
    task automatic rd(input logic [15:0] a);
        step(0, 1, 0, a, 8'h00, 0);
    endtask
    task automatic idle(input bit ack);
        step(0, 0, 0, 16'h1234, 8'h00, ack);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp += 3;
            if (data_out !== e.dout) begin
                n_err++;
                $display("FAIL data_out t=%0t got %02h want %02h", $time, data_out, e.dout);
            end
            if (cmd !== e.cmd) begin
                n_err++;
                $display("FAIL cmd t=%0t got %02h want %02h", $time, cmd, e.cmd);
            end
            if (cmd_valid !== e.vld) begin
                n_err++;
                $display("FAIL cmd_valid t=%0t got %0b want %0b", $time, cmd_valid, e.vld);
            end
        end
    end

    initial begin
        reset = 0; enable = 0; write_en = 0; addr = '0; data_in = '0; cmd_ack = 0;
        step(1, 0, 0, 16'h0, 8'h0, 0);
        step(1, 1, 1, REG, 8'hEE, 1);
        rd(REG); rd(STAT); idle(0);
        wr(REG, 8'hA5, 0); rd(STAT); idle(1); rd(STAT); rd(REG);
        wr(REG, 8'hFF, 0); idle(1); idle(1); rd(REG);
        wr(REG, 8'h11, 0);
        for (int i = 0; i < 3; i++) wr(REG, 8'h11, 0);
        rd(STAT);
        for (int i = 0; i < 20; i++) wr(REG, 8'h22, 0);
        rd(STAT); wr(STAT, 8'h02, 0); rd(STAT);
        wr(STAT, 8'hFD, 1); idle(1); wr(REG, 8'hA5, 0); wr(REG, 8'h5A, 1); rd(STAT); rd(REG);
        wr(REG, 8'h33, 0); rd(STAT);
        step(1, 1, 0, STAT, 8'h00, 0); rd(STAT); rd(REG);
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [15:0] a;
            r = $urandom_range(0, 9);
            a = (r < 4) ? REG : (r < 8) ? STAT : 16'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 a, 8'($urandom), $urandom_range(0, 2) == 0);
        end
        idle(0);
        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
